// File: rtl/acc_mem_responder.sv
// Accelerator memory block: dual-port byte-writable line store with read-first
// semantics, 1- or 2-cycle read latency and a sticky write-collision flag.
module acc_mem_rd_port #(
    parameter int DATA_WIDTH   = 128,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    logic [READ_LATENCY:1] vld_q;
    logic [READ_LATENCY:0] vld_pipe;

    assign vld_pipe = {vld_q, rd_req};

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[READ_LATENCY-1:0];
    end

    // A read in flight when reset arrives must never surface, even on the reset cycle.
    assign rd_valid = vld_pipe[READ_LATENCY] & ~rst;

    generate
        if (READ_LATENCY == 2) begin : g_oreg
            logic [DATA_WIDTH-1:0] out_q;
            always_ff @(posedge clk) begin
                if (rst)           out_q <= '0;
                else if (vld_pipe[1]) out_q <= rd_word;
            end
            assign rd_data = out_q;
        end else begin : g_direct
            assign rd_data = rd_word;
        end
    endgenerate
endmodule

module acc_mem_responder #(
    parameter int DATA_WIDTH     = 128,
    parameter int STRB_WIDTH     = DATA_WIDTH/8,
    parameter int ACC_ADDR_WIDTH = 12,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      acc_en_b1,
    input  logic [STRB_WIDTH-1:0]     acc_wen_b1,
    input  logic [ACC_ADDR_WIDTH-1:0] acc_addr_b1,
    input  logic [DATA_WIDTH-1:0]     acc_wr_data_b1,
    output logic [DATA_WIDTH-1:0]     acc_rd_data_b1,
    output logic                      acc_rd_valid_b1,
    input  logic                      acc_en_b2,
    input  logic [STRB_WIDTH-1:0]     acc_wen_b2,
    input  logic [ACC_ADDR_WIDTH-1:0] acc_addr_b2,
    input  logic [DATA_WIDTH-1:0]     acc_wr_data_b2,
    output logic [DATA_WIDTH-1:0]     acc_rd_data_b2,
    output logic                      acc_rd_valid_b2,
    output logic                      error,
    output logic [ACC_ADDR_WIDTH-1:0] error_addr,
    input  logic                      error_ack
);
    localparam int NUM_PORTS = 2;
    localparam int DEPTH     = 2**ACC_ADDR_WIDTH;

    typedef enum logic {ERR_IDLE, ERR_SET} err_state_t;

    logic [NUM_PORTS-1:0]                     en_v;
    logic [NUM_PORTS-1:0][STRB_WIDTH-1:0]     wen_v;
    logic [NUM_PORTS-1:0][ACC_ADDR_WIDTH-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_v;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rd_word;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rd_data_v;
    logic [NUM_PORTS-1:0]                     rd_valid_v;
    logic [NUM_PORTS-1:0]                     rd_req;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    err_state_t state, state_nxt;
    logic       collision;
    logic       err_cap;

    assign en_v    = {acc_en_b2, acc_en_b1};
    assign wen_v   = {acc_wen_b2, acc_wen_b1};
    assign addr_v  = {acc_addr_b2, acc_addr_b1};
    assign wdata_v = {acc_wr_data_b2, acc_wr_data_b1};

    always_comb begin
        rd_req = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            rd_req[p] = en_v[p] & ~(|wen_v[p]) & ~rst;
    end

    // Port 2 is applied first so port 1 overwrites any byte both ports target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = NUM_PORTS-1; p >= 0; p--) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (en_v[p] && wen_v[p][b])
                        mem[addr_v[p]][b*8 +: 8] <= wdata_v[p][b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking capture gives the pre-edge line, i.e. read-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (rd_req[p]) rd_word[p] <= mem[addr_v[p]];
        end
    end

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            acc_mem_rd_port #(
                .DATA_WIDTH  (DATA_WIDTH),
                .READ_LATENCY(READ_LATENCY)
            ) u_rd_port (
                .clk     (clk),
                .rst     (rst),
                .rd_req  (rd_req[p]),
                .rd_word (rd_word[p]),
                .rd_data (rd_data_v[p]),
                .rd_valid(rd_valid_v[p])
            );
        end
    endgenerate

    assign acc_rd_data_b1  = rd_data_v[0];
    assign acc_rd_data_b2  = rd_data_v[1];
    assign acc_rd_valid_b1 = rd_valid_v[0];
    assign acc_rd_valid_b2 = rd_valid_v[1];

    assign collision = en_v[0] & en_v[1] & (addr_v[0] == addr_v[1]) & (|(wen_v[0] & wen_v[1]));

    always_ff @(posedge clk) begin
        if (rst) state <= ERR_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ERR_IDLE: if (collision) state_nxt = ERR_SET;
            ERR_SET:  if (error_ack && !collision) state_nxt = ERR_IDLE;
            default:  state_nxt = ERR_IDLE;
        endcase
    end

    always_comb begin
        error   = (state == ERR_SET);
        // Latch the address on a fresh error, or when an ack and a new collision coincide.
        err_cap = collision & ((state == ERR_IDLE) | error_ack);
    end

    always_ff @(posedge clk) begin
        if (rst)          error_addr <= '0;
        else if (err_cap) error_addr <= addr_v[0];
    end
endmodule
